// File: rtl/audio_pkg.sv
// audio_pkg: shared sample/velocity types, voice FSM states and scaling constants.
package audio_pkg;
    typedef logic signed [15:0] sample_t;
    typedef logic [6:0] velocity_t;
    typedef enum logic [1:0] {IDLE, FETCH, SCALE, PRESENT} voice_state_t;
    localparam int VEL_SHIFT = 7;
endpackage

// File: rtl/velocity_scaler.sv
// velocity_scaler: registered signed sample times unsigned velocity, shifted right by VEL_SHIFT.
module velocity_scaler
    import audio_pkg::*;
#(
    parameter int VEL_WIDTH = 7
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [15:0]          din,
    input  logic [VEL_WIDTH-1:0] vel,
    output logic [15:0]          dout
);
    localparam int PW = 16 + VEL_WIDTH + 1;
    logic signed [PW-1:0] prod;
    logic unused_prod;
    // velocity is zero-extended so it multiplies as a non-negative gain below 1.0
    assign prod = PW'($signed(din)) * PW'($signed({1'b0, vel}));
    assign unused_prod = ^{prod[PW-1:VEL_SHIFT+16], prod[VEL_SHIFT-1:0]};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dout <= '0;
        else if (en) dout <= prod[VEL_SHIFT+15:VEL_SHIFT];
    end
endmodule

// File: rtl/sample_voice.sv
// sample_voice: single PCM playback voice streaming words from memory to a valid/ready lane.
// Define SAMPLE_VOICE_VELOCITY_EN to add the registered velocity multiply (SCALE state).
module sample_voice
    import audio_pkg::*;
#(
    parameter int ADDR_WIDTH = 24,
    parameter int VEL_WIDTH  = 7
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  trigger,
    input  logic [VEL_WIDTH-1:0]  trigger_velocity,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH-1:0] sample_len,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_rvalid,
    input  logic [15:0]           mem_rdata,
    output logic [15:0]           dout,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic                  active
);
    localparam logic [ADDR_WIDTH-1:0] ONE = 1;
    voice_state_t state;
    logic [ADDR_WIDTH-1:0] addr, remaining;
    logic [VEL_WIDTH-1:0] vel;
    logic pending, discard;
    logic note_on, note_off, rd_done, busy;
    assign note_off = trigger && trigger_velocity == '0;
    assign note_on  = trigger && trigger_velocity != '0 && sample_len != '0;
    assign rd_done  = pending && mem_rvalid;
    // a read that is still in flight after this cycle blocks a new request
    assign busy     = pending && !mem_rvalid;
`ifdef SAMPLE_VOICE_VELOCITY_EN
    logic [15:0] scaled;
    velocity_scaler #(.VEL_WIDTH(VEL_WIDTH)) u_scaler (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (rd_done),
        .din  (mem_rdata),
        .vel  (vel),
        .dout (scaled)
    );
`else
    logic unused_vel;
    assign unused_vel = ^vel;
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            addr       <= '0;
            remaining  <= '0;
            vel        <= '0;
            pending    <= 1'b0;
            discard    <= 1'b0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            active     <= 1'b0;
        end else begin
            mem_req <= 1'b0;
            if (rd_done) begin
                pending <= 1'b0;
                discard <= 1'b0;
            end
            if (note_on) begin
                state      <= FETCH;
                active     <= 1'b1;
                dout_valid <= 1'b0;
                addr       <= start_addr;
                remaining  <= sample_len;
                vel        <= trigger_velocity;
                discard    <= busy;
                if (!busy) begin
                    mem_req  <= 1'b1;
                    mem_addr <= start_addr;
                    pending  <= 1'b1;
                end
            end else if (note_off) begin
                state      <= IDLE;
                active     <= 1'b0;
                dout_valid <= 1'b0;
            end else begin
                case (state)
                    FETCH: if (rd_done) begin
                        if (discard) begin
                            mem_req  <= 1'b1;
                            mem_addr <= addr;
                            pending  <= 1'b1;
                        end else begin
`ifdef SAMPLE_VOICE_VELOCITY_EN
                            state <= SCALE;
`else
                            dout       <= mem_rdata;
                            dout_valid <= 1'b1;
                            state      <= PRESENT;
`endif
                        end
                    end
`ifdef SAMPLE_VOICE_VELOCITY_EN
                    SCALE: begin
                        dout       <= scaled;
                        dout_valid <= 1'b1;
                        state      <= PRESENT;
                    end
`endif
                    PRESENT: if (dout_ready) begin
                        dout_valid <= 1'b0;
                        addr       <= addr + ONE;
                        remaining  <= remaining - ONE;
                        if (remaining == ONE) begin
                            state  <= IDLE;
                            active <= 1'b0;
                        end else begin
                            state    <= FETCH;
                            mem_req  <= 1'b1;
                            mem_addr <= addr + ONE;
                            pending  <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: doc/sample_voice.md
Name: sample_voice

Overview:
- One playback voice per instrument. On a trigger it streams 16-bit signed PCM samples from sample memory, scales each by note velocity, and presents them one at a time on a valid/ready port.
- Sits directly upstream of sample_mixer: one instance per instrument, driving one din/din_valid/din_ready lane.
- The mixer raises ready once per sample period (about 2272 cycles), so each voice supplies at most one sample per period.

Parameters:
- ADDR_WIDTH, 24, width of sample memory word address and of sample length.
- VEL_WIDTH, 7, velocity width (MIDI range 0..127).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- trigger  in  1  single-cycle note event.
- trigger_velocity  in  VEL_WIDTH  velocity sampled with trigger.
- start_addr  in  ADDR_WIDTH  first sample word address, sampled with trigger.
- sample_len  in  ADDR_WIDTH  sample count, sampled with trigger.
- mem_req  out  1  single-cycle read request.
- mem_addr  out  ADDR_WIDTH  read address, valid while mem_req=1.
- mem_rvalid  in  1  read data return; exactly one per mem_req, arbitrary latency of 1 or more cycles.
- mem_rdata  in  16  signed PCM word, valid with mem_rvalid.
- dout  out  16  signed scaled sample to the mixer.
- dout_valid  out  1  sample available.
- dout_ready  in  1  mixer ready; handshake is dout_valid & dout_ready.
- active  out  1  voice playing (state is not IDLE).

Behaviour:
- Reset: asynchronous on rst_n=0. Forces state=IDLE and clears the discard flag. Outputs: dout=0, dout_valid=0, mem_req=0, mem_addr=0, active=0.
- States:
  - IDLE: wait for trigger.
  - FETCH: issue mem_req for one cycle, then wait for mem_rvalid.
  - SCALE: register the product.
  - PRESENT: hold dout and dout_valid until handshake.
- Trigger acceptance:
  - A trigger with velocity≠0 and sample_len≠0 is accepted in any state.
  - It latches addr=start_addr, remaining=sample_len, vel=trigger_velocity.
  - Next state is FETCH. mem_req pulses the cycle after the trigger.
- Note-off: a trigger with velocity=0 goes to IDLE next cycle, and dout_valid drops next cycle.
- Ignored trigger: a trigger with velocity≠0 and sample_len=0 is ignored entirely; current playback continues.
- Retrigger while a read is outstanding (in FETCH after mem_req was issued):
  - Set the discard flag. The next mem_rvalid is dropped, then a fresh mem_req is issued for the new start_addr.
  - Only one read is ever outstanding.
  - A retrigger or note-off during PRESENT drops dout_valid the next cycle; the stale sample is never handshaked afterwards.
- Fetch to present:
  - mem_rvalid in cycle R (not discarded) leads to SCALE at R+1.
  - dout_valid=1 from R+2, with dout = (mem_rdata * {1'b0,vel}) >>> 7.
  - The multiply is signed 16×8 to a 24-bit product, arithmetic right shift, keeping bits [22:7].
  - No saturation is needed, since gain ≤ 127/128. Example: -32768 at vel 127 gives -32512.
- Handshake:
  - On handshake, dout_valid falls next cycle, remaining decrements and addr increments.
  - If remaining becomes 0, go to IDLE (active falls next cycle). Otherwise go to FETCH and issue mem_req next cycle, so the next sample is prefetched well inside one sample period.
- dout holds its last value after dout_valid falls. The mixer ignores it without a handshake.
- Trigger in the same cycle as a handshake: the handshake counts as consumed, and the trigger wins the state transition.
- addr wraps modulo 2^ADDR_WIDTH. No bounds checking.
- A mem_rvalid arriving in IDLE without an outstanding read is ignored.

Optional Feature:
- Macro: SAMPLE_VOICE_VELOCITY_EN.
- Defined: velocity scaling as above; the SCALE state is present; dout_valid rises at R+2.
- Undefined: SCALE is bypassed and dout=mem_rdata unscaled; dout_valid rises at R+1. Velocity is still latched and still used for note-off (velocity 0).

Decomposition:
- Package audio_pkg:
  - sample_t (logic signed [15:0]).
  - velocity_t.
  - voice_state_t enum {IDLE, FETCH, SCALE, PRESENT}.
  - VEL_SHIFT=7.
- Sub-module velocity_scaler: registered signed multiply-and-shift, one cycle latency, instantiated only under SAMPLE_VOICE_VELOCITY_EN.

Test Plan:
- Basic play: trigger, start_addr=0x100, sample_len=3, vel=127; memory latency 3 with data 1000, -1000, 32767; ready after 10 cycles → mem_addr 0x100, 0x101, 0x102; dout 992, -993, 32511; active falls after the 3rd handshake; exactly 3 mem_req.
- Note-off: note-off (vel=0) during PRESENT → dout_valid=0 next cycle, active=0, no further mem_req.
- Retrigger mid-fetch: retrigger at start_addr=0x200 during a 5-cycle-latency read → first return discarded; next mem_addr=0x200; first presented sample is from 0x200.
- Zero length: sample_len=0 trigger while idle → no mem_req, active stays 0; the same trigger while playing leaves playback unchanged.
- Mixer timing: connect to sample_mixer (INSTRUMENT_COUNT=4, SAMPLE_PERIOD=2272), play 5 samples → exactly one handshake per period, mixer dout equals the scaled sample.
- Async reset mid-PRESENT: rst_n low between clock edges → all outputs 0 immediately; no mem_req for 2 cycles after release without a trigger.
